// File: rtl/stereo_decorrelator.sv
// Stereo decorrelator: buffers channel 0 of a FLAC frame, then combines it with channel 1
// to emit interleaved left/right PCM pairs (independent, L/S, S/R, M/S, mono pass-through).
module stereo_decorrelator #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iEnable,
    input  logic                       iFrameStart,
    input  logic [3:0]                 iChanAssign,
    input  logic [15:0]                iBlockSize,
    input  logic                       iSampleValid,
    input  logic signed [SAMPLE_W:0]   iSample,
    output logic                       oValid,
    output logic signed [SAMPLE_W-1:0] oLeft,
    output logic signed [SAMPLE_W-1:0] oRight,
    output logic                       oFrameDone,
    output logic                       oBadFrame
);

    localparam int unsigned IN_W  = SAMPLE_W + 1;
    localparam int unsigned CW    = SAMPLE_W + 2;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {S_IDLE, S_CH0, S_CH1, S_MONO, S_DROP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, blk_q;
    logic [3:0]         asg_q;
    logic               fs, acc, take, emit, last_cnt, start_bad, assign_ok, size_ok;

    logic [IN_W-1:0]    mem [DEPTH];
    logic [IN_W-1:0]    rd_q, c1_q;
    logic               v1, last1, mono1;
    logic [3:0]         mode1;

    logic signed [CW-1:0] a, b, m, ms_sum, ms_dif, l_c, r_c;

    assign fs       = iEnable & iFrameStart;
    assign acc      = iEnable & iSampleValid;
    assign last_cnt = (cnt == CNT_W'(blk_q - 16'd1));
    assign size_ok  = (iBlockSize != 16'd0) && (32'(iBlockSize) <= DEPTH);
    assign emit     = take && (state != S_CH0);

    always_comb begin
        case (iChanAssign)
            4'd0, 4'd1, 4'd8, 4'd9, 4'd10: assign_ok = 1'b1;
            default:                       assign_ok = 1'b0;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) state <= S_IDLE;
        else        state <= state_d;
    end

    // Frame start overrides everything, including a sample presented in the same cycle.
    always_comb begin
        state_d   = state;
        take      = 1'b0;
        start_bad = 1'b0;
        if (fs) begin
            if (!(assign_ok && size_ok)) begin
                state_d   = S_DROP;
                start_bad = 1'b1;
            end else if (iChanAssign == 4'd0) begin
                state_d = S_MONO;
            end else begin
                state_d = S_CH0;
            end
        end else if (acc) begin
            case (state)
                S_CH0: begin
                    take = 1'b1;
                    if (last_cnt) state_d = S_CH1;
                end
                S_CH1, S_MONO: begin
                    take = 1'b1;
                    if (last_cnt) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            cnt       <= '0;
            blk_q     <= '0;
            asg_q     <= '0;
            oBadFrame <= 1'b0;
        end else if (fs) begin
            cnt       <= '0;
            blk_q     <= iBlockSize;
            asg_q     <= iChanAssign;
            oBadFrame <= start_bad;
        end else if (take) begin
            cnt <= last_cnt ? '0 : CNT_W'(cnt + 16'd1);
        end
    end

    // Channel 0 buffer; the read address is the channel 1 index so data lines up with c1_q.
    always_ff @(posedge iClock) begin
        if (take && state == S_CH0) mem[cnt[ADDR_W-1:0]] <= iSample;
        if (iEnable)                rd_q <= mem[cnt[ADDR_W-1:0]];
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            mono1 <= 1'b0;
            mode1 <= '0;
            c1_q  <= '0;
        end else if (iEnable) begin
            v1    <= emit;
            last1 <= emit && last_cnt;
            mono1 <= (state == S_MONO);
            mode1 <= asg_q;
            c1_q  <= iSample;
        end
    end

    // Channel reconstruction in SAMPLE_W+2 bits, truncated on output.
    always_comb begin
        a      = {rd_q[IN_W-1], rd_q};
        b      = {c1_q[IN_W-1], c1_q};
        m      = {a[CW-2:0], b[0]};
        ms_sum = m + b;
        ms_dif = m - b;
        l_c    = a;
        r_c    = b;
        if (mono1) begin
            l_c = b;
            r_c = b;
        end else begin
            case (mode1)
                4'd8:    r_c = a - b;
                4'd9:    l_c = a + b;
                4'd10: begin
                    l_c = ms_sum >>> 1;
                    r_c = ms_dif >>> 1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oValid     <= 1'b0;
            oFrameDone <= 1'b0;
            oLeft      <= '0;
            oRight     <= '0;
        end else if (iEnable) begin
            oValid     <= v1;
            oFrameDone <= last1;
            if (v1) begin
                oLeft  <= SAMPLE_W'(l_c);
                oRight <= SAMPLE_W'(r_c);
            end
        end
    end

endmodule

// File: tb/tb_stereo_decorrelator.sv
// Scoreboard bench for stereo_decorrelator: expected pairs are queued as samples are driven
// and checked (values, frame-done flag and 2-clock latency) when oValid fires.
module tb_stereo_decorrelator;

    logic               iClock = 1'b0;
    logic               iReset;
    logic               iEnable;
    logic               iFrameStart;
    logic [3:0]         iChanAssign;
    logic [15:0]        iBlockSize;
    logic               iSampleValid;
    logic signed [16:0] iSample;
    logic               oValid;
    logic signed [15:0] oLeft;
    logic signed [15:0] oRight;
    logic               oFrameDone;
    logic               oBadFrame;

    stereo_decorrelator #(.SAMPLE_W(16), .ADDR_W(12)) dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable),
        .iFrameStart(iFrameStart), .iChanAssign(iChanAssign), .iBlockSize(iBlockSize),
        .iSampleValid(iSampleValid), .iSample(iSample),
        .oValid(oValid), .oLeft(oLeft), .oRight(oRight),
        .oFrameDone(oFrameDone), .oBadFrame(oBadFrame)
    );

    always #5 iClock = ~iClock;

    int cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    typedef struct {
        logic signed [15:0] l;
        logic signed [15:0] r;
        logic               done;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    int ms_c0 [4096];
    int ms_c1 [4096];
    int ms_l  [4096];
    int ms_r  [4096];

    // Output monitor: every oValid must match the head of the scoreboard at the expected cycle.
    always @(negedge iClock) begin
        if (oValid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pair: got L=%0d R=%0d at cyc %0d, required no output", oLeft, oRight, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (oLeft !== mon_e.l || oRight !== mon_e.r || oFrameDone !== mon_e.done || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL pair: got L=%0d R=%0d done=%b cyc=%0d, required L=%0d R=%0d done=%b cyc=%0d",
                             oLeft, oRight, oFrameDone, cyc, mon_e.l, mon_e.r, mon_e.done, mon_e.cyc);
                end
            end
        end else if (oFrameDone !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_frame_done: got oFrameDone=%b without oValid at cyc %0d, required 0", oFrameDone, cyc);
        end
    end

    task automatic frame(input int asg, input int bs);
        @(posedge iClock); #1;
        iFrameStart  = 1'b1;
        iChanAssign  = 4'(asg);
        iBlockSize   = 16'(bs);
        iSampleValid = 1'b0;
    endtask

    task automatic send(input int s, input bit chk, input int l, input int r, input bit done);
        exp_t e;
        @(posedge iClock); #1;
        iFrameStart  = 1'b0;
        iSampleValid = 1'b1;
        iSample      = 17'(s);
        if (chk) begin
            e.l    = 16'(l);
            e.r    = 16'(r);
            e.done = done;
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge iClock); #1;
        iFrameStart  = 1'b0;
        iSampleValid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge iClock);
        repeat (3) @(posedge iClock);
        #1;
    endtask

    task automatic test_reset();
        iReset = 1'b1; iEnable = 1'b1; iFrameStart = 1'b0; iChanAssign = '0;
        iBlockSize = '0; iSampleValid = 1'b0; iSample = '0;
        repeat (3) @(posedge iClock);
        #1;
        checks++; if (oValid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b, required 0", oValid); end
        checks++; if (oLeft !== 16'sd0)    begin errors++; $display("FAIL reset_left: got %0d, required 0", oLeft); end
        checks++; if (oRight !== 16'sd0)   begin errors++; $display("FAIL reset_right: got %0d, required 0", oRight); end
        checks++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", oFrameDone); end
        checks++; if (oBadFrame !== 1'b0)  begin errors++; $display("FAIL reset_bad: got %b, required 0", oBadFrame); end
        @(posedge iClock); #1;
        iReset = 1'b0;
    endtask

    task automatic test_indep();
        frame(1, 4);
        for (int i = 1; i <= 4; i++) send(i, 1'b0, 0, 0, 1'b0);
        for (int i = 1; i <= 4; i++) send(-i, 1'b1, i, -i, i == 4);
        idle();
        wait_drain();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL indep_drain: got %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_ls_sr();
        frame(8, 1);
        send(100, 1'b0, 0, 0, 1'b0);
        send(30, 1'b1, 100, 70, 1'b1);
        frame(9, 1);
        send(-5, 1'b0, 0, 0, 1'b0);
        send(10, 1'b1, 5, 10, 1'b1);
        frame(8, 1);
        send(-32768, 1'b0, 0, 0, 1'b0);
        send(-65535, 1'b1, -32768, 32767, 1'b1);
        idle();
        wait_drain();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ls_sr_drain: got %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_ms();
        frame(10, 2);
        send(5, 1'b0, 0, 0, 1'b0);
        send(-3, 1'b0, 0, 0, 1'b0);
        send(3, 1'b1, 7, 4, 1'b0);
        send(-1, 1'b1, -3, -2, 1'b1);
        idle();
        wait_drain();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ms_small_drain: got %0d outstanding, required 0", sb.size()); sb.delete(); end
        // Random L/R encoded to mid/side; decoder must reproduce L/R exactly at full depth.
        for (int i = 0; i < 4096; i++) begin
            ms_l[i]  = int'($urandom_range(65535)) - 32768;
            ms_r[i]  = int'($urandom_range(65535)) - 32768;
            ms_c1[i] = ms_l[i] - ms_r[i];
            ms_c0[i] = (ms_l[i] + ms_r[i]) >>> 1;
        end
        ms_l[0] = 32767;  ms_r[0] = -32768; ms_c1[0] = 65535;  ms_c0[0] = -1;
        ms_l[1] = -32768; ms_r[1] = 32767;  ms_c1[1] = -65535; ms_c0[1] = -1;
        frame(10, 4096);
        for (int i = 0; i < 4096; i++) send(ms_c0[i], 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 4096; i++) send(ms_c1[i], 1'b1, ms_l[i], ms_r[i], i == 4095);
        idle();
        wait_drain();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ms_full_drain: got %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_mono();
        frame(0, 3);
        send(7, 1'b1, 7, 7, 1'b0);
        send(-8, 1'b1, -8, -8, 1'b0);
        send(9, 1'b1, 9, 9, 1'b1);
        send(11, 1'b0, 0, 0, 1'b0);
        idle();
        wait_drain();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL mono_drain: got %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_bad_frame();
        frame(12, 3);
        for (int i = 0; i < 6; i++) send(i + 1, 1'b0, 0, 0, 1'b0);
        idle();
        checks++; if (oBadFrame !== 1'b1) begin errors++; $display("FAIL bad_assign: got oBadFrame=%b, required 1", oBadFrame); end
        frame(1, 0);
        idle();
        checks++; if (oBadFrame !== 1'b1) begin errors++; $display("FAIL bad_size0: got oBadFrame=%b, required 1", oBadFrame); end
        send(5, 1'b0, 0, 0, 1'b0);
        frame(1, 4097);
        idle();
        checks++; if (oBadFrame !== 1'b1) begin errors++; $display("FAIL bad_size4097: got oBadFrame=%b, required 1", oBadFrame); end
        send(5, 1'b0, 0, 0, 1'b0);
        frame(1, 2);
        idle();
        checks++; if (oBadFrame !== 1'b0) begin errors++; $display("FAIL good_clears_bad: got oBadFrame=%b, required 0", oBadFrame); end
        send(11, 1'b0, 0, 0, 1'b0);
        send(22, 1'b0, 0, 0, 1'b0);
        send(-5, 1'b1, 11, -5, 1'b0);
        send(6, 1'b1, 22, 6, 1'b1);
        idle();
        wait_drain();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL bad_recover_drain: got %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_abort();
        frame(1, 3);
        for (int i = 1; i <= 3; i++) send(i, 1'b0, 0, 0, 1'b0);
        send(10, 1'b1, 1, 10, 1'b0);
        send(20, 1'b1, 2, 20, 1'b0);
        frame(9, 1);
        send(4, 1'b0, 0, 0, 1'b0);
        send(6, 1'b1, 10, 6, 1'b1);
        idle();
        wait_drain();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL abort_drain: got %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid();
        frame(1, 4);
        send(5, 1'b0, 0, 0, 1'b0);
        send(6, 1'b0, 0, 0, 1'b0);
        @(posedge iClock); #1;
        iSampleValid = 1'b0;
        iReset = 1'b1;
        #1;
        checks++; if (oValid !== 1'b0)     begin errors++; $display("FAIL rst_mid_valid: got %b, required 0", oValid); end
        checks++; if (oLeft !== 16'sd0)    begin errors++; $display("FAIL rst_mid_left: got %0d, required 0", oLeft); end
        checks++; if (oRight !== 16'sd0)   begin errors++; $display("FAIL rst_mid_right: got %0d, required 0", oRight); end
        checks++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b, required 0", oFrameDone); end
        checks++; if (oBadFrame !== 1'b0)  begin errors++; $display("FAIL rst_mid_bad: got %b, required 0", oBadFrame); end
        @(posedge iClock); #1;
        iReset = 1'b0;
        send(7, 1'b0, 0, 0, 1'b0);
        idle();
        frame(1, 1);
        send(3, 1'b0, 0, 0, 1'b0);
        send(4, 1'b1, 3, 4, 1'b1);
        idle();
        wait_drain();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_recover_drain: got %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_indep();
        test_ls_sr();
        test_ms();
        test_mono();
        test_bad_frame();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
